// File: rtl/vga_timing_ctrl_if.sv
// Bus between the VGA timing controller and its consumers (framebuffer reader,
// overlay logic, pin drivers). The controller drives timing; the consumer drives en.
interface vga_timing_ctrl_if #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 20
);
    logic              en;
    logic [WIDTH-1:0]  hdata;
    logic [WIDTH-1:0]  vdata;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_req;
    logic              hsync;
    logic              vsync;
    logic              data_enable;
    logic              line_start;
    logic              frame_start;
    logic [15:0]       frame_count;

    modport master (
        input  en,
        output hdata, vdata, fb_addr, fb_req, hsync, vsync, data_enable,
               line_start, frame_start, frame_count
    );

    modport slave (
        output en,
        input  hdata, vdata, fb_addr, fb_req, hsync, vsync, data_enable,
               line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: raw pixel/line counters, replicated framebuffer address,
// and sync/enable delayed by LAT enabled pixels to line up with framebuffer data.
module vga_timing_ctrl #(
    parameter int   WIDTH  = 12,
    parameter int   HSIZE  = 800,
    parameter int   HFP    = 856,
    parameter int   HSP    = 976,
    parameter int   HMAX   = 1040,
    parameter int   VSIZE  = 600,
    parameter int   VFP    = 637,
    parameter int   VSP    = 643,
    parameter int   VMAX   = 666,
    parameter logic HSPP   = 1'b1,
    parameter logic VSPP   = 1'b1,
    parameter int   LAT    = 2,
    parameter int   SCALE  = 0,
    parameter int   ADDR_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    vga_timing_ctrl_if.master   bus
);
    localparam logic [WIDTH-1:0]  HSIZE_W  = WIDTH'(HSIZE);
    localparam logic [WIDTH-1:0]  HFP_W    = WIDTH'(HFP);
    localparam logic [WIDTH-1:0]  HSP_W    = WIDTH'(HSP);
    localparam logic [WIDTH-1:0]  H_LAST   = WIDTH'(HMAX - 1);
    localparam logic [WIDTH-1:0]  VSIZE_W  = WIDTH'(VSIZE);
    localparam logic [WIDTH-1:0]  VFP_W    = WIDTH'(VFP);
    localparam logic [WIDTH-1:0]  VSP_W    = WIDTH'(VSP);
    localparam logic [WIDTH-1:0]  V_LAST   = WIDTH'(VMAX - 1);
    localparam logic [WIDTH:0]    VSIZE_X  = (WIDTH+1)'(VSIZE);
    localparam logic [WIDTH:0]    SMASK    = (WIDTH+1)'((1 << SCALE) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(HSIZE >> SCALE);

    logic              en;
    logic [WIDTH-1:0]  hcnt, vcnt;
    logic [ADDR_W-1:0] row_base;
    logic [15:0]       frame_cnt;
    logic [WIDTH:0]    v_inc;
    logic [WIDTH-1:0]  h_scaled;
    logic              line_end, frame_end;
    logic              vis_raw, hs_raw, vs_raw;

    assign en        = bus.en;
    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign v_inc     = {1'b0, vcnt} + (WIDTH+1)'(1);
    assign h_scaled  = hcnt >> SCALE;

    assign vis_raw = (hcnt < HSIZE_W) && (vcnt < VSIZE_W);
    assign hs_raw  = ((hcnt >= HFP_W) && (hcnt < HSP_W)) ? HSPP : ~HSPP;
    assign vs_raw  = ((vcnt >= VFP_W) && (vcnt < VSP_W)) ? VSPP : ~VSPP;

    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            row_base  <= '0;
            frame_cnt <= '0;
        end else if (en) begin
            hcnt <= line_end ? '0 : hcnt + WIDTH'(1);
            if (line_end) begin
                // row_base advances once per 2^SCALE visible lines, never via a multiply
                if (vcnt == V_LAST) begin
                    vcnt     <= '0;
                    row_base <= '0;
                end else begin
                    vcnt <= vcnt + WIDTH'(1);
                    if ((v_inc < VSIZE_X) && ((v_inc & SMASK) == '0))
                        row_base <= row_base + ROW_STEP;
                end
            end
            if (frame_end)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

    generate
        if (LAT == 0) begin : g_nodly
            assign bus.hsync       = hs_raw;
            assign bus.vsync       = vs_raw;
            assign bus.data_enable = vis_raw;
        end else begin : g_dly
            logic [LAT-1:0] hs_q, vs_q, de_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    hs_q <= {LAT{~HSPP}};
                    vs_q <= {LAT{~VSPP}};
                    de_q <= '0;
                end else if (en) begin
                    hs_q <= LAT'({hs_q, hs_raw});
                    vs_q <= LAT'({vs_q, vs_raw});
                    de_q <= LAT'({de_q, vis_raw});
                end
            end
            assign bus.hsync       = hs_q[LAT-1];
            assign bus.vsync       = vs_q[LAT-1];
            assign bus.data_enable = de_q[LAT-1];
        end
    endgenerate

    assign bus.hdata       = hcnt;
    assign bus.vdata       = vcnt;
    assign bus.fb_addr     = row_base + ADDR_W'(h_scaled);
    assign bus.fb_req      = vis_raw;
    assign bus.line_start  = en && !rst && (hcnt == '0);
    assign bus.frame_start = en && !rst && (hcnt == '0) && (vcnt == '0);
    assign bus.frame_count = frame_cnt;
endmodule
